// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV64 NPC datapath.
// Walks each instruction through fetch, execute, optional load/store and
// write-back. It drives the memory handshakes and releases the RegisterFile
// and PC write enables exactly once per committed instruction.
//
// Handshake rule: a request is transferred on a rising edge where valid and
// ready are both high. valid is raised from a register and stays high, with
// constant attributes, until that edge. Responses are only looked at in the
// WAIT state that belongs to them.
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_in,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    input  logic        dec_is_mem,
    input  logic        dec_reg_write,
    input  logic        dec_ebreak,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        reg_we,
    output logic        pc_we,
    output logic        halted,
    output logic        bus_err,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        HALT       = 3'd6,
        ERROR      = 3'd7
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_cnt;
    logic       in_timed;
    logic       launch;
    logic       tmo_hit;

    logic       imem_req_valid_nxt;
    logic       lsu_req_valid_nxt;
    logic       pc_we_nxt;
    logic       halted_nxt;
    logic       bus_err_nxt;

    // Only the handshake states are watched by the timeout counter. The cycle
    // right after reset (FETCH_REQ with the request not yet out) is not counted.
    assign in_timed = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                      (state == MEM_REQ)   || (state == MEM_WAIT);
    assign launch   = (state == FETCH_REQ) && !imem_req_valid;
    assign tmo_hit  = in_timed && !launch && (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A completed handshake takes priority over a timeout
    // that expires in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_REQ:  if (imem_req_valid && imem_req_ready) state_nxt = FETCH_WAIT;
            FETCH_WAIT: if (imem_rsp_valid) state_nxt = EXEC;
            EXEC: begin
                if (dec_ebreak)      state_nxt = HALT;
                else if (dec_is_mem) state_nxt = MEM_REQ;
                else                 state_nxt = WB;
            end
            MEM_REQ:    if (lsu_req_valid && lsu_req_ready) state_nxt = MEM_WAIT;
            MEM_WAIT:   if (lsu_rsp_valid) state_nxt = WB;
            WB:         state_nxt = FETCH_REQ;
            HALT:       state_nxt = HALT;
            ERROR:      state_nxt = ERROR;
            default:    state_nxt = ERROR;
        endcase
        if ((state_nxt == state) && tmo_hit) begin
            state_nxt = ERROR;
        end
    end

    // Output decode from the next state. These values are registered so the
    // outputs stay glitch-free and are all zero while reset is applied.
    always_comb begin
        imem_req_valid_nxt = (state_nxt == FETCH_REQ);
        lsu_req_valid_nxt  = (state_nxt == MEM_REQ);
        pc_we_nxt          = (state_nxt == WB);
        halted_nxt         = (state_nxt == HALT);
        bus_err_nxt        = (state_nxt == ERROR);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid <= 1'b0;
            lsu_req_valid  <= 1'b0;
            pc_we          <= 1'b0;
            halted         <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            imem_req_valid <= imem_req_valid_nxt;
            lsu_req_valid  <= lsu_req_valid_nxt;
            pc_we          <= pc_we_nxt;
            halted         <= halted_nxt;
            bus_err        <= bus_err_nxt;
        end
    end

    // The IFU keeps pc_in constant until pc_we, so the address is stable while valid is high.
    assign imem_req_addr = imem_req_valid ? pc_in : 64'd0;
    // The write-back qualifier comes from the decoder of the latched instruction.
    assign reg_we        = pc_we & dec_reg_write;

    // Timeout counter: cleared on each state change, counts cycles spent in a handshake state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
        end else if ((state_nxt != state) || !in_timed || launch) begin
            tmo_cnt <= 8'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Instruction latch: loaded only by a response that arrives in FETCH_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= NOP;
        end else if ((state == FETCH_WAIT) && imem_rsp_valid) begin
            inst <= imem_rsp_data;
        end
    end

    // Retired-instruction counter. It advances once per WB and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 64'd0;
        end else if (state == WB) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Testbench for core_seq_ctrl. It covers table-driven instruction
// transactions, randomized wait states checked against a latency and
// retire-count model, and hand-written ebreak, reset and timeout sequences.
module tb_core_seq_ctrl;

    localparam int unsigned TMO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_in = 64'h8000_0000;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] inst;
    logic        dec_is_mem = 1'b0;
    logic        dec_reg_write = 1'b0;
    logic        dec_ebreak = 1'b0;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        reg_we;
    logic        pc_we;
    logic        halted;
    logic        bus_err;
    logic [63:0] instret;

    core_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(inst),
        .dec_is_mem(dec_is_mem), .dec_reg_write(dec_reg_write), .dec_ebreak(dec_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .reg_we(reg_we), .pc_we(pc_we),
        .halted(halted), .bus_err(bus_err), .instret(instret)
    );

    // Clock.
    always #5 clk = ~clk;

    // One instruction transaction: wait states plus the expected WB position,
    // counted in cycles from the first cycle the fetch request is visible.
    typedef struct {
        int          frdy;
        int          frsp;
        int          lrdy;
        int          lrsp;
        bit          mem;
        bit          rw;
        bit          spur;
        logic [31:0] ins;
        int          exp_lat;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_instret = 64'd0;
    logic [31:0] exp_inst = NOP;
    logic [63:0] cur_pc = 64'h8000_0000;
    vec_t        vecs[6];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Model of latency: one cycle per state visited, plus each wait state.
    function automatic int model_lat(vec_t v);
        int lat;
        lat = 4 + v.frdy + v.frsp;
        if (v.mem) lat = lat + 2 + v.lrdy + v.lrsp;
        return lat;
    endfunction

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        lsu_req_ready  = 1'b0;
        lsu_rsp_valid  = 1'b0;
        dec_is_mem     = 1'b0;
        dec_reg_write  = 1'b0;
        dec_ebreak     = 1'b0;
    endtask

    // Apply reset, check the reset values, then release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_ctrl_outs", {62'd0, imem_req_valid, lsu_req_valid}, 64'd0);
        check("rst_we_outs", {62'd0, reg_we, pc_we}, 64'd0);
        check("rst_sticky", {62'd0, halted, bus_err}, 64'd0);
        check("rst_addr", imem_req_addr, 64'd0);
        check("rst_inst", {32'd0, inst}, {32'd0, NOP});
        check("rst_instret", instret, 64'd0);
        rst_n = 1'b1;
        exp_instret = 64'd0;
        exp_inst = NOP;
        #1;
        check("rst_release_no_req", {63'd0, imem_req_valid}, 64'd0);
    endtask

    // Drive one full instruction through fetch, optional LSU and WB, then check it.
    task automatic run_instr(input vec_t v);
        int phase = 0;
        int cyc = 0;
        int lat = 0;
        int vcnt = 0;
        int wcnt = 0;
        int lvcnt = 0;
        int lwcnt = 0;
        int errs = 0;
        while (phase != 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (vcnt > 0) lat++;
            if (pc_we && phase < 2) errs++;
            if (reg_we !== (pc_we && v.rw)) errs++;
            if (inst !== exp_inst) errs++;
            if (phase == 0) begin
                imem_req_ready = 1'b0;
                imem_rsp_valid = v.spur;
                imem_rsp_data  = 32'hdead_beef;
                if (lsu_req_valid) errs++;
                if (imem_req_valid) begin
                    if (vcnt == 0) begin
                        lat = 1;
                        check("instret_before", instret, exp_instret);
                    end
                    vcnt++;
                    if (imem_req_addr !== cur_pc) errs++;
                    if (vcnt == v.frdy + 1) begin
                        imem_req_ready = 1'b1;
                        phase = 1;
                    end
                end
            end else if (phase == 1) begin
                imem_req_ready = 1'b0;
                if (imem_req_valid || lsu_req_valid) errs++;
                imem_rsp_valid = (wcnt == v.frsp);
                imem_rsp_data  = imem_rsp_valid ? v.ins : 32'hdead_beef;
                wcnt++;
                if (imem_rsp_valid) begin
                    dec_is_mem    = v.mem;
                    dec_reg_write = v.rw;
                    dec_ebreak    = 1'b0;
                    exp_inst      = v.ins;
                    phase = 2;
                end
            end else begin
                imem_rsp_valid = 1'b0;
                lsu_req_ready  = 1'b0;
                lsu_rsp_valid  = 1'b0;
                if (imem_req_valid) errs++;
                if (lsu_req_valid && (!v.mem || phase == 3)) errs++;
                if (pc_we) begin
                    phase = 4;
                end else if (phase == 2 && lsu_req_valid) begin
                    lvcnt++;
                    if (lvcnt == v.lrdy + 1) begin
                        lsu_req_ready = 1'b1;
                        phase = 3;
                    end
                end else if (phase == 3) begin
                    lsu_rsp_valid = (lwcnt == v.lrsp);
                    lwcnt++;
                end
            end
        end
        check("wb_reached", {63'd0, phase == 4}, 64'd1);
        check("wb_latency", 64'(lat), 64'(v.exp_lat));
        check("protocol_errs", 64'(errs), 64'd0);
        clear_inputs();
        dec_reg_write = v.rw;
        dec_is_mem = v.mem;
        exp_instret = exp_instret + 64'd1;
        cur_pc = {32'd0, $urandom()} & ~64'd3;
        pc_in = cur_pc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   found;
        int   viol;
        int   vcnt;
        vec_t rv;

        // Directed transactions: hand-computed WB positions.
        vecs[0] = '{frdy:0, frsp:0, lrdy:0, lrsp:0, mem:0, rw:1, spur:0, ins:32'h0050_0093, exp_lat:4};
        vecs[1] = '{frdy:3, frsp:2, lrdy:0, lrsp:0, mem:0, rw:1, spur:0, ins:32'h00a0_0113, exp_lat:9};
        vecs[2] = '{frdy:0, frsp:0, lrdy:0, lrsp:5, mem:1, rw:1, spur:0, ins:32'h0000_b183, exp_lat:11};
        vecs[3] = '{frdy:1, frsp:0, lrdy:2, lrsp:1, mem:1, rw:0, spur:1, ins:32'h0030_b423, exp_lat:10};
        vecs[4] = '{frdy:2, frsp:1, lrdy:0, lrsp:0, mem:0, rw:1, spur:1, ins:32'h0020_8233, exp_lat:7};
        vecs[5] = '{frdy:0, frsp:0, lrdy:0, lrsp:0, mem:1, rw:1, spur:0, ins:32'h0000_a283, exp_lat:6};

        do_reset();
        for (int i = 0; i < 6; i++) run_instr(vecs[i]);

        // Randomized wait states, all below the timeout.
        for (int i = 0; i < 24; i++) begin
            rv.frdy = int'($urandom_range(0, 5));
            rv.frsp = int'($urandom_range(0, 5));
            rv.lrdy = int'($urandom_range(0, 5));
            rv.lrsp = int'($urandom_range(0, 5));
            rv.mem  = 1'($urandom_range(0, 1));
            rv.rw   = 1'($urandom_range(0, 1));
            rv.spur = 1'($urandom_range(0, 1));
            rv.ins  = $urandom();
            rv.exp_lat = model_lat(rv);
            run_instr(rv);
        end

        // Reset asserted while a load waits for its LSU response.
        dec_is_mem = 1'b1;
        dec_reg_write = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (imem_req_valid) found = 1;
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0000_b183;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (lsu_req_valid) found = 1;
        end
        check("midrst_lsu_req", 64'(found), 64'd1);
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        @(negedge clk);
        check("midrst_instret_before", instret, exp_instret);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outs_async", {58'd0, imem_req_valid, lsu_req_valid, reg_we, pc_we, halted, bus_err}, 64'd0);
        check("midrst_instret_async", instret, 64'd0);
        check("midrst_inst_async", {32'd0, inst}, {32'd0, NOP});
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        exp_instret = 64'd0;
        exp_inst = NOP;
        run_instr(vecs[0]);
        @(negedge clk);
        check("midrst_instret_after", instret, 64'd1);

        // ebreak: halt with no commit and no further fetches.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = EBREAK;
        dec_ebreak = 1'b1;
        dec_is_mem = 1'b0;
        dec_reg_write = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("ebreak_inst", {32'd0, inst}, {32'd0, EBREAK});
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            imem_req_ready = 1'b1;
            if (pc_we || reg_we || imem_req_valid || lsu_req_valid) viol++;
        end
        imem_req_ready = 1'b0;
        check("ebreak_quiet", 64'(viol), 64'd0);
        check("ebreak_halted", {63'd0, halted}, 64'd1);
        check("ebreak_no_err", {63'd0, bus_err}, 64'd0);
        check("ebreak_instret", instret, 64'd1);

        // Fetch timeout: ready never comes.
        do_reset();
        vcnt = 0;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (bus_err) found = 1;
            else if (imem_req_valid) vcnt++;
        end
        check("tmo_bus_err", 64'(found), 64'd1);
        check("tmo_valid_cycles", 64'(vcnt), 64'(TMO));
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            imem_req_ready = 1'b1;
            if (pc_we || reg_we || imem_req_valid || lsu_req_valid || !bus_err) viol++;
        end
        check("tmo_quiesce", 64'(viol), 64'd0);
        check("tmo_not_halted", {63'd0, halted}, 64'd0);
        check("tmo_instret", instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
